// File: rtl/dds_param_ctrl.sv
// -----------------------------------------------------------------------------
// dds_param_ctrl
//
// Per-channel parameter controller for the DDS datapath. A host writes shadow
// registers through a valid/ready command port. A commit strobe copies every
// channel's shadow set to the active outputs in one edge. Each channel can also
// run a linear frequency sweep, either one-shot or wrapping.
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-low reset
//   cmd_valid     command present
//   cmd_ready     controller accepts a command (high in RUN)
//   cmd_ch        target channel
//   cmd_reg       register index (0 phase, 1 amp, 2 shape, 3 stop, 4 step,
//                 5 divider, 6 ctrl{wrap,sweep_en}, 7 reserved)
//   cmd_data      write data, LSB-aligned
//   commit        one-cycle pulse, shadow -> active for all channels
//   phase_M       active phase increments, channel 0 in the LSBs
//   signal_A      active amplitudes
//   signal_shape  active waveform shapes (0 sin, 1 triangle, 2 square)
//   sweep_active  sweep running, one bit per channel
//   cmd_err       one-cycle pulse after a rejected command
// -----------------------------------------------------------------------------
module dds_param_ctrl #(
    parameter int CH_NUM      = 2,
    parameter int PHASE_W     = 15,
    parameter int AMP_W       = 11,
    parameter int AMP_MAX     = 2047,
    parameter int PH_DEFAULT  = 500,
    parameter int AMP_DEFAULT = 1200,
    parameter int DIV_W       = 16,
    localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    localparam int DATA_W     = (PHASE_W > DIV_W) ? PHASE_W : DIV_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [CH_W-1:0]           cmd_ch,
    input  logic [2:0]                cmd_reg,
    input  logic [DATA_W-1:0]         cmd_data,
    input  logic                      commit,
    output logic [CH_NUM*PHASE_W-1:0] phase_M,
    output logic [CH_NUM*AMP_W-1:0]   signal_A,
    output logic [CH_NUM*2-1:0]       signal_shape,
    output logic [CH_NUM-1:0]         sweep_active,
    output logic                      cmd_err
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t state_reg, state_next;
    logic   load_all;       // copy shadows to active this edge
    logic   cmd_acc;        // command handshake completes this edge
    logic   cmd_bad;        // command is rejected
    logic   wr_ok;          // command writes a shadow register
    logic   ch_oob;
    logic   cmd_err_reg;
    logic [AMP_W-1:0] amp_wr;

    // One extra bit so that an out-of-range channel is representable even
    // when CH_NUM is a power of two (the compare is then simply never true).
    localparam logic [CH_W:0] CH_LIMIT = (CH_W+1)'(CH_NUM);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        load_all   = 1'b0;
        case (state_reg)
            ST_INIT: begin
                // The post-reset shadows (defaults) are pushed out exactly once;
                // any commit pulse seen here is redundant and therefore ignored.
                load_all   = 1'b1;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                cmd_ready = 1'b1;
                load_all  = commit;
            end
            default: state_next = ST_INIT;
        endcase
    end

    // ---------------------------------------------------- command decode
    assign cmd_acc = cmd_valid && cmd_ready;
    assign ch_oob  = ({1'b0, cmd_ch} >= CH_LIMIT);
    assign cmd_bad = (cmd_reg == 3'd7) ||
                     ((cmd_reg == 3'd2) && (cmd_data[1:0] == 2'd3)) ||
                     ch_oob;
    assign wr_ok   = cmd_acc && !cmd_bad;

    // Amplitude saturates instead of wrapping into the narrower register.
    assign amp_wr = (cmd_data > DATA_W'(AMP_MAX)) ? AMP_W'(AMP_MAX)
                                                  : cmd_data[AMP_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_err_reg <= 1'b0;
        end else begin
            cmd_err_reg <= cmd_acc && cmd_bad;
        end
    end

    assign cmd_err = cmd_err_reg;

    // ------------------------------------------------------ per channel
    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
            logic               wr_sel;
            // shadow set
            logic [PHASE_W-1:0] sh_phase_reg, sh_phase_next;
            logic [AMP_W-1:0]   sh_amp_reg,   sh_amp_next;
            logic [1:0]         sh_shape_reg, sh_shape_next;
            logic [PHASE_W-1:0] sh_stop_reg,  sh_stop_next;
            logic [PHASE_W-1:0] sh_step_reg,  sh_step_next;
            logic [DIV_W-1:0]   sh_div_reg,   sh_div_next;
            logic [1:0]         sh_ctrl_reg,  sh_ctrl_next;
            // active set
            logic [PHASE_W-1:0] phase_reg;
            logic [AMP_W-1:0]   amp_reg;
            logic [1:0]         shape_reg;
            logic               active_reg;
            // sweep parameters latched at commit
            logic [PHASE_W-1:0] run_start_reg;
            logic [PHASE_W-1:0] run_stop_reg;
            logic [PHASE_W-1:0] run_step_reg;
            logic [DIV_W-1:0]   run_div_reg;
            logic               run_wrap_reg;
            logic [DIV_W-1:0]   div_cnt_reg;
            logic               wrap_pend_reg;  // next step reloads start
            logic [PHASE_W:0]   step_sum;       // carry kept in the MSB

            assign wr_sel = wr_ok && (cmd_ch == CH_W'(gi));

            // Shadow next values; commit reads these, so a write in the
            // commit cycle is already included.
            always_comb begin
                sh_phase_next = sh_phase_reg;
                sh_amp_next   = sh_amp_reg;
                sh_shape_next = sh_shape_reg;
                sh_stop_next  = sh_stop_reg;
                sh_step_next  = sh_step_reg;
                sh_div_next   = sh_div_reg;
                sh_ctrl_next  = sh_ctrl_reg;
                if (wr_sel) begin
                    case (cmd_reg)
                        3'd0:    sh_phase_next = cmd_data[PHASE_W-1:0];
                        3'd1:    sh_amp_next   = amp_wr;
                        3'd2:    sh_shape_next = cmd_data[1:0];
                        3'd3:    sh_stop_next  = cmd_data[PHASE_W-1:0];
                        3'd4:    sh_step_next  = cmd_data[PHASE_W-1:0];
                        3'd5:    sh_div_next   = cmd_data[DIV_W-1:0];
                        3'd6:    sh_ctrl_next  = cmd_data[1:0];
                        default: ;
                    endcase
                end
            end

            assign step_sum = {1'b0, phase_reg} + {1'b0, run_step_reg};

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sh_phase_reg  <= PHASE_W'(PH_DEFAULT);
                    sh_amp_reg    <= AMP_W'(AMP_DEFAULT);
                    sh_shape_reg  <= '0;
                    sh_stop_reg   <= '0;
                    sh_step_reg   <= '0;
                    sh_div_reg    <= '0;
                    sh_ctrl_reg   <= '0;
                    phase_reg     <= '0;
                    amp_reg       <= '0;
                    shape_reg     <= '0;
                    active_reg    <= 1'b0;
                    run_start_reg <= '0;
                    run_stop_reg  <= '0;
                    run_step_reg  <= '0;
                    run_div_reg   <= '0;
                    run_wrap_reg  <= 1'b0;
                    div_cnt_reg   <= '0;
                    wrap_pend_reg <= 1'b0;
                end else begin
                    sh_phase_reg <= sh_phase_next;
                    sh_amp_reg   <= sh_amp_next;
                    sh_shape_reg <= sh_shape_next;
                    sh_stop_reg  <= sh_stop_next;
                    sh_step_reg  <= sh_step_next;
                    sh_div_reg   <= sh_div_next;
                    sh_ctrl_reg  <= sh_ctrl_next;

                    if (load_all) begin
                        // Static load and sweep (re)start share this path:
                        // phase always begins at the shadow phase.
                        amp_reg       <= sh_amp_next;
                        shape_reg     <= sh_shape_next;
                        phase_reg     <= sh_phase_next;
                        run_start_reg <= sh_phase_next;
                        run_stop_reg  <= sh_stop_next;
                        run_step_reg  <= sh_step_next;
                        run_div_reg   <= sh_div_next;
                        run_wrap_reg  <= sh_ctrl_next[1];
                        active_reg    <= sh_ctrl_next[0];
                        div_cnt_reg   <= '0;
                        wrap_pend_reg <= 1'b0;
                    end else if (active_reg) begin
                        if (div_cnt_reg == run_div_reg) begin
                            div_cnt_reg <= '0;
                            // A zero step freezes the sweep without ending it.
                            if (run_step_reg != '0) begin
                                if (wrap_pend_reg) begin
                                    phase_reg     <= run_start_reg;
                                    wrap_pend_reg <= 1'b0;
                                end else if (step_sum >= {1'b0, run_stop_reg}) begin
                                    // Also catches overflow: the carry makes
                                    // step_sum exceed any PHASE_W-bit stop.
                                    phase_reg <= run_stop_reg;
                                    if (run_wrap_reg) begin
                                        wrap_pend_reg <= 1'b1;
                                    end else begin
                                        active_reg <= 1'b0;
                                    end
                                end else begin
                                    phase_reg <= step_sum[PHASE_W-1:0];
                                end
                            end
                        end else begin
                            div_cnt_reg <= div_cnt_reg + 1'b1;
                        end
                    end
                end
            end

            assign phase_M[gi*PHASE_W +: PHASE_W] = phase_reg;
            assign signal_A[gi*AMP_W +: AMP_W]    = amp_reg;
            assign signal_shape[gi*2 +: 2]        = shape_reg;
            assign sweep_active[gi]               = active_reg;
        end
    endgenerate

endmodule
